// File: rtl/uart_mem_dumper.sv
// uart_mem_dumper
//   Walks a word-addressed RAM from address 0 and streams every 32-bit word
//   out of an 8N1 UART transmitter, little-endian byte order, LSB first.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset; aborts a dump in any state
//   start      one-cycle request to begin a dump; only honoured in IDLE
//   mem_addr   word address to the RAM (registered)
//   mem_rdata  RAM read data, valid one cycle after mem_addr changes
//   Tx_Serial  registered UART output, idle high
//   busy       high from the cycle after start is accepted until done
//   done       one-cycle pulse after the final stop bit
module uart_mem_dumper #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int ADDR_WIDTH   = 8,
    parameter int WORD_COUNT   = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [31:0]           mem_rdata,
    output logic                  Tx_Serial,
    output logic                  busy,
    output logic                  done
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0]         T_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_WIDTH-1:0] W_LAST = ADDR_WIDTH'(WORD_COUNT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_LATCH, S_START, S_DATA, S_STOP, S_DONE
    } state_t;

    state_t                r_state;
    logic [TW-1:0]         r_timer;
    logic [2:0]            r_bit;
    logic [1:0]            r_byte;
    logic [31:0]           r_shift;
    logic [ADDR_WIDTH-1:0] r_word;   // word counter, doubles as mem_addr
    logic                  r_tx;
    logic                  r_busy;
    logic                  r_done;
    logic                  w_bit_end;

    assign w_bit_end = (r_timer == T_LAST);

    assign mem_addr  = r_word;
    assign Tx_Serial = r_tx;
    assign busy      = r_busy;
    assign done      = r_done;

    // Tx_Serial is loaded on the same edge that changes state, so the line
    // level always matches the state being entered and never glitches.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_timer <= '0;
            r_bit   <= '0;
            r_byte  <= '0;
            r_shift <= '0;
            r_word  <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    if (start) begin
                        r_state <= S_ADDR;
                        r_word  <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                // One cycle for the RAM to return data for r_word.
                S_ADDR: r_state <= S_LATCH;
                S_LATCH: begin
                    r_shift <= mem_rdata;
                    r_byte  <= '0;
                    r_timer <= '0;
                    r_tx    <= 1'b0;
                    r_state <= S_START;
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_timer <= '0;
                        r_bit   <= '0;
                        r_tx    <= r_shift[0];
                        r_state <= S_DATA;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                // The word shifts right one bit per data bit, so after eight
                // bits the next byte already sits in r_shift[7:0].
                S_DATA: begin
                    if (w_bit_end) begin
                        r_timer <= '0;
                        r_shift <= r_shift >> 1;
                        if (r_bit == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            r_bit <= r_bit + 3'd1;
                            r_tx  <= r_shift[1];
                        end
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        r_timer <= '0;
                        if (r_byte != 2'd3) begin
                            r_byte  <= r_byte + 2'd1;
                            r_tx    <= 1'b0;
                            r_state <= S_START;
                        end else if (r_word != W_LAST) begin
                            r_word  <= r_word + ADDR_WIDTH'(1);
                            r_state <= S_ADDR;
                        end else begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_DONE;
                        end
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_mem_dumper.sv
// tb_uart_mem_dumper
//   Directed bench for uart_mem_dumper with CLKS_PER_BIT=4, WORD_COUNT=2 and
//   a one-cycle-latency RAM. A dump is captured per cycle into arrays
//   (index 0 = first cycle after start is accepted) and then decoded.
module tb_uart_mem_dumper;

    localparam int CPB = 4;
    localparam int WC  = 2;
    localparam int AW  = 8;
    localparam int N   = 400;
    localparam int RUN = 2 * (40 * CPB + 2) + 1;  // 325 samples, done at 324

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_rdata;
    logic          tx;
    logic          busy;
    logic          done;

    logic [31:0]   ram [2];
    logic [63:0]   exp_stream;

    logic          txw [N];
    logic          bw  [N];
    logic          dw  [N];
    logic [AW-1:0] aw  [N];

    int checks = 0;
    int fails  = 0;

    uart_mem_dumper #(
        .CLKS_PER_BIT (CPB),
        .ADDR_WIDTH   (AW),
        .WORD_COUNT   (WC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .Tx_Serial (tx),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) mem_rdata <= ram[mem_addr[0]];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    // Sample from the current negedge onward, n cycles.
    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            txw[i] = tx;
            bw[i]  = busy;
            dw[i]  = done;
            aw[i]  = mem_addr;
        end
    endtask

    task automatic check_dump(input string tag);
        int       i;
        int       ne;
        int       e;
        int       ferr;
        int       berr;
        int       derr;
        int       lerr;
        int       run;
        int       edges [8];
        logic [7:0] by [8];
        ne = 0; ferr = 0; berr = 0; derr = 0; lerr = 0;
        for (int k = 0; k < 8; k++) begin
            edges[k] = -1;
            by[k]    = 8'h00;
        end
        // UART decode: find falling edge, sample mid-bit.
        i = 1;
        while (i < RUN) begin
            if (txw[i] === 1'b0 && txw[i-1] === 1'b1) begin
                e = i;
                if (ne < 8) begin
                    edges[ne] = e;
                    if (e + 39 < RUN) begin
                        if (txw[e+2] !== 1'b0) ferr++;
                        for (int b = 0; b < 8; b++) by[ne][b] = txw[e + 4*(b+1) + 2];
                        if (txw[e+38] !== 1'b1) ferr++;
                    end
                end
                ne++;
                i = e + 39;
            end else begin
                i++;
            end
        end
        chk({tag, "_nbytes"}, ne, 8);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("%s_byte%0d", tag, k), {24'h0, by[k]}, {24'h0, exp_stream[8*k +: 8]});
            chk($sformatf("%s_edge%0d", tag, k), edges[k], 2 + (k/4)*162 + (k%4)*40);
        end
        chk({tag, "_framing"}, ferr, 0);
        // Within a word, every constant level lasts a multiple of CPB.
        for (int w = 0; w < 2; w++) begin
            run = 1;
            for (int j = 2 + 162*w + 1; j < 162 + 162*w; j++) begin
                if (txw[j] === txw[j-1]) run++;
                else begin
                    if (run % CPB != 0) lerr++;
                    run = 1;
                end
            end
            if (run % CPB != 0) lerr++;
        end
        chk({tag, "_runlen"}, lerr, 0);
        chk({tag, "_gap"}, {28'h0, txw[0], txw[1], txw[162], txw[163]}, 32'hF);
        for (int j = 0; j < RUN; j++) begin
            if (bw[j] !== (j < RUN - 1)) berr++;
            if (dw[j] !== (j == RUN - 1)) derr++;
        end
        chk({tag, "_busy"}, berr, 0);
        chk({tag, "_done"}, derr, 0);
        chk({tag, "_addr0"},   aw[0],   0);
        chk({tag, "_addr161"}, aw[161], 0);
        chk({tag, "_addr162"}, aw[162], 1);
        chk({tag, "_addrend"}, aw[RUN-1], 1);
    endtask

    initial begin
        int viol;
        ram[0]     = 32'h12345678;
        ram[1]     = 32'hA5A5FF00;
        exp_stream = 64'hA5A5FF00_12345678;
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_tx",   tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_addr", mem_addr, 0);

        // Idle: nothing moves without start.
        viol = 0;
        repeat (1000) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) viol++;
        end
        chk("idle_viol", viol, 0);

        // Reset wins over start in the same cycle.
        start = 1'b1; reset = 1'b1;
        @(negedge clk);
        start = 1'b0; reset = 1'b0;
        @(negedge clk);
        chk("rst_prio_busy", busy, 0);
        chk("rst_prio_tx", tx, 1);

        // Single dump.
        pulse_start();
        capture(RUN);
        check_dump("d1");

        // Back-to-back: start raised during the done cycle (ignored) and held
        // into the following IDLE cycle (accepted).
        start = 1'b1;
        @(negedge clk);
        @(negedge clk) start = 1'b0;
        capture(RUN);
        check_dump("b2b");

        // Start pulsed mid-byte while busy.
        @(negedge clk);
        pulse_start();
        fork
            capture(RUN);
            begin
                repeat (60) @(negedge clk);
                start = 1'b1;
                @(negedge clk) start = 1'b0;
            end
        join
        check_dump("busy_st");
        viol = 0;
        repeat (400) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0 || tx !== 1'b1) viol++;
        end
        chk("busy_st_after", viol, 0);

        // Reset in the middle of word 0 byte 1 data bits (index 55).
        pulse_start();
        repeat (55) @(negedge clk);
        chk("mid_busy_pre", busy, 1);
        reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        chk("mid_rst_tx",   tx, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_addr", mem_addr, 0);
        chk("mid_rst_done", done, 0);
        viol = 0;
        repeat (200) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0 || tx !== 1'b1) viol++;
        end
        chk("mid_rst_quiet", viol, 0);
        pulse_start();
        capture(RUN);
        check_dump("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
